// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU-side bus in, downstream memory-mapped bus out.
// The slave modport is the engine's view; master is the environment driving the CPU side.
interface oam_dma_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_indata;
    logic [7:0]  cpu_outdata;
    logic        cpu_load;
    logic        cpu_store;
    logic [15:0] address;
    logic [7:0]  outdata;
    logic [7:0]  indata;
    logic        load;
    logic        store;
    logic        dma_active;

    modport slave (
        input  cpu_address,
        input  cpu_indata,
        input  cpu_load,
        input  cpu_store,
        input  indata,
        output cpu_outdata,
        output address,
        output outdata,
        output load,
        output store,
        output dma_active
    );

    modport master (
        output cpu_address,
        output cpu_indata,
        output cpu_load,
        output cpu_store,
        output indata,
        input  cpu_outdata,
        input  address,
        input  outdata,
        input  load,
        input  store,
        input  dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine behind register FF46: copies a 160-byte page into FE00-FE9F while
// owning the downstream bus, letting only HRAM traffic through in free phases.
module oam_dma #(
    parameter logic [15:0] DMA_ADDR    = 16'hff46,
    parameter logic [15:0] OAM_BASE    = 16'hfe00,
    parameter int unsigned OAM_BYTES   = 160,
    parameter int unsigned BYTE_CLOCKS = 4
) (
    input  logic     clockgb,
    input  logic     reset,
    oam_dma_if.slave bus
);

    localparam int unsigned        PHASE_W    = $clog2(BYTE_CLOCKS);
    localparam logic [7:0]         LAST_IDX   = 8'(OAM_BYTES - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTE_CLOCKS - 1);
    localparam logic [PHASE_W-1:0] PH_LOAD    = PHASE_W'(0);
    localparam logic [PHASE_W-1:0] PH_CAPT    = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_STORE   = PHASE_W'(2);
    localparam logic [15:0]        HRAM_LO    = 16'hff80;
    localparam logic [15:0]        HRAM_HI    = 16'hfffe;
    localparam logic [7:0]         ECHO_HI    = 8'he0;
    localparam logic [7:0]         ECHO_OFS   = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2
    } state_e;

    // What cpu_outdata should present in the cycle after a CPU load.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_FWD  = 2'd1,
        RD_REG  = 2'd2,
        RD_BLK  = 2'd3
    } rd_sel_e;

    state_e             state_q, state_d;
    logic [7:0]         src_hi_q, src_hi_d;
    logic [7:0]         idx_q, idx_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         latch_q, latch_d;
    rd_sel_e            rd_sel_q, rd_sel_d;
    logic [7:0]         rd_val_q, rd_val_d;

    logic        cpu_is_reg;
    logic        reg_wr;
    logic        reg_rd;
    logic        active;
    logic        dma_ld_phase;
    logic        dma_st_phase;
    logic        cpu_hram;
    logic        cpu_fwd;
    logic [7:0]  src_eff;
    logic [15:0] src_addr;
    logic [15:0] oam_addr;

    // Shared decode of the CPU request and the current transfer slot.
    always_comb begin
        cpu_is_reg   = (bus.cpu_address == DMA_ADDR);
        reg_wr       = bus.cpu_store && cpu_is_reg;
        reg_rd       = bus.cpu_load && !bus.cpu_store && cpu_is_reg;
        active       = (state_q != S_IDLE);
        dma_ld_phase = (state_q == S_XFER) && (phase_q == PH_LOAD);
        dma_st_phase = (state_q == S_XFER) && (phase_q == PH_STORE);
        cpu_hram     = (bus.cpu_address >= HRAM_LO) && (bus.cpu_address <= HRAM_HI);
        cpu_fwd      = !cpu_is_reg &&
                       (!active || (cpu_hram && !dma_ld_phase && !dma_st_phase));
        src_eff      = (src_hi_q >= ECHO_HI) ? (src_hi_q - ECHO_OFS) : src_hi_q;
        src_addr     = {src_eff, 8'h00} + {8'h00, idx_q};
        oam_addr     = OAM_BASE + {8'h00, idx_q};
    end

    // State and datapath registers.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            state_q  <= S_IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            phase_q  <= PHASE_W'(0);
            latch_q  <= 8'h00;
            rd_sel_q <= RD_NONE;
            rd_val_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            latch_q  <= latch_d;
            rd_sel_q <= rd_sel_d;
            rd_val_q <= rd_val_d;
        end
    end

    // Next-state: an FF46 store always (re)starts from byte 0 with the new source.
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        phase_d  = phase_q;
        latch_d  = latch_q;
        rd_sel_d = RD_NONE;
        rd_val_d = rd_val_q;

        if (reg_wr) begin
            src_hi_d = bus.cpu_indata;
        end

        case (state_q)
            S_IDLE: begin
                if (reg_wr) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                idx_d   = 8'h00;
                phase_d = PHASE_W'(0);
                state_d = reg_wr ? S_START : S_XFER;
            end
            S_XFER: begin
                if (reg_wr) begin
                    state_d = S_START;
                end else begin
                    if (phase_q == PH_CAPT) begin
                        latch_d = bus.indata;
                    end
                    if (phase_q == LAST_PHASE) begin
                        phase_d = PHASE_W'(0);
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reg_rd) begin
            rd_sel_d = RD_REG;
            rd_val_d = src_hi_q;
        end else if (bus.cpu_load && !cpu_is_reg) begin
            rd_sel_d = cpu_fwd ? RD_FWD : RD_BLK;
        end
    end

    // Downstream bus drive; the DMA slot wins, and a restarting store suppresses it.
    always_comb begin
        bus.address    = bus.cpu_address;
        bus.outdata    = bus.cpu_indata;
        bus.load       = 1'b0;
        bus.store      = 1'b0;
        bus.dma_active = active;

        if (dma_ld_phase && !reg_wr) begin
            bus.address = src_addr;
            bus.load    = 1'b1;
        end else if (dma_st_phase && !reg_wr) begin
            bus.address = oam_addr;
            bus.outdata = latch_q;
            bus.store   = 1'b1;
        end else if (cpu_fwd) begin
            bus.load  = bus.cpu_load;
            bus.store = bus.cpu_store;
        end

        case (rd_sel_q)
            RD_FWD:  bus.cpu_outdata = bus.indata;
            RD_REG:  bus.cpu_outdata = rd_val_q;
            RD_BLK:  bus.cpu_outdata = 8'hff;
            default: bus.cpu_outdata = 8'h00;
        endcase
    end

endmodule
